// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and the load-use detector for the hazard control unit.
// State constants stay plain localparams so existing code that compares against them keeps working.
package hazard_ctrl_pkg;

    localparam logic [1:0] HC_IDLE   = 2'd0;
    localparam logic [1:0] HC_JFLUSH = 2'd1;
    localparam logic [1:0] HC_BUSY   = 2'd2;
    localparam logic [1:0] HC_EXTH   = 2'd3;

    localparam logic [4:0] ZERO_REG    = 5'd0;
    localparam int         FLUSH_CNT_W = 4;

    // x0 is hardwired to zero, so a load that targets it can never create a dependency.
    function automatic logic load_use_hit(
        input logic       ex_load,
        input logic       ex_wen,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic       rs1_ren,
        input logic [4:0] rs2,
        input logic       rs2_ren
    );
        return ex_load && ex_wen && (ex_rd != ZERO_REG) &&
               ((rs1_ren && (rs1 == ex_rd)) || (rs2_ren && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Pair of free-running wrap counters for flushed and stalled cycles.
// Compiled only when HAZARD_PERF_CNT_EN is defined, so the default build carries no counter flops.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_inc,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: jump flush > busy EX unit > load-use bubble > external hold.
// Define HAZARD_PERF_CNT_EN to add flush/stall performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int JUMP_FLUSH_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             ex_busy_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs1_ren_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs2_ren_i,
    input  logic             ext_hold_i,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             stall_if_id_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [FLUSH_CNT_W-1:0] JFC_LOAD = FLUSH_CNT_W'(JUMP_FLUSH_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_use;

    assign load_use = load_use_hit(ex_load_i, ex_reg_wen_i, ex_rd_addr_i,
                                   id_rs1_addr_i, id_rs1_ren_i,
                                   id_rs2_addr_i, id_rs2_ren_i);

    // Outputs are combinational so the PC and stage registers react in the hazard cycle itself;
    // holding reset also forces them low even while the inputs still request action.
    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        hold_pc_o     = 1'b0;
        stall_if_id_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (rst) begin
            if (jump_en_i) begin
                jump_en_o     = 1'b1;
                jump_addr_o   = jump_addr_i;
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (state_q == HC_JFLUSH) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (ex_busy_i) begin
                // id_ex keeps the multi-cycle instruction, so only the front end is frozen.
                hold_pc_o     = 1'b1;
                stall_if_id_o = 1'b1;
            end else if (load_use || ext_hold_i) begin
                hold_pc_o     = 1'b1;
                stall_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end
        end
    end

    // cnt_q holds the flush cycles still owed, including the current JFLUSH cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (jump_en_i) begin
            if (JUMP_FLUSH_CYCLES > 1) begin
                state_d = HC_JFLUSH;
                cnt_d   = JFC_LOAD;
            end else begin
                state_d = HC_IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == HC_JFLUSH) begin
            if (cnt_q <= 1) begin
                state_d = HC_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (ex_busy_i) begin
            state_d = HC_BUSY;
        end else if (ext_hold_i) begin
            state_d = HC_EXTH;
        end else begin
            state_d = HC_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HC_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic jump_flush;

    assign jump_flush = flush_id_ex_o && (jump_en_i || (state_q == HC_JFLUSH));

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .flush_inc (jump_flush),
        .stall_inc (hold_pc_o),
        .flush_cnt (flush_cnt_o),
        .stall_cnt (stall_cnt_o)
    );
`else
    assign flush_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 flush cycles) share stimulus and are compared
// every cycle against a priority-rule model, plus hand-computed directed expectations.
module tb_hazard_ctrl;

    localparam int JFC_A = 1;
    localparam int JFC_B = 3;
    localparam int CW    = 8;

    typedef struct packed {
        logic        jump_en;
        logic [31:0] addr;
        logic        hold;
        logic        stall;
        logic        fif;
        logic        fidex;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_busy_i, ex_load_i, ex_reg_wen_i;
    logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
    logic        id_rs1_ren_i, id_rs2_ren_i, ext_hold_i;

    logic          a_jump_en, a_hold, a_stall, a_fif, a_fidex;
    logic [31:0]   a_addr;
    logic [CW-1:0] a_fcnt, a_scnt;
    logic          b_jump_en, b_hold, b_stall, b_fif, b_fidex;
    logic [31:0]   b_addr;
    logic [CW-1:0] b_fcnt, b_scnt;

    int total = 0;
    int bad   = 0;

    // Model state: flush cycles still owed after a jump, and ideal counter values.
    int rem_a, rem_b, fc_a, sc_a, fc_b, sc_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.JUMP_FLUSH_CYCLES(JFC_A), .CNT_W(CW)) u_dut_a (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_reg_wen_i(ex_reg_wen_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_ren_i(id_rs1_ren_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_ren_i(id_rs2_ren_i), .ext_hold_i(ext_hold_i),
        .jump_en_o(a_jump_en), .jump_addr_o(a_addr), .hold_pc_o(a_hold),
        .stall_if_id_o(a_stall), .flush_if_id_o(a_fif), .flush_id_ex_o(a_fidex),
        .flush_cnt_o(a_fcnt), .stall_cnt_o(a_scnt)
    );

    hazard_ctrl #(.JUMP_FLUSH_CYCLES(JFC_B), .CNT_W(CW)) u_dut_b (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_reg_wen_i(ex_reg_wen_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_ren_i(id_rs1_ren_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_ren_i(id_rs2_ren_i), .ext_hold_i(ext_hold_i),
        .jump_en_o(b_jump_en), .jump_addr_o(b_addr), .hold_pc_o(b_hold),
        .stall_if_id_o(b_stall), .flush_if_id_o(b_fif), .flush_id_ex_o(b_fidex),
        .flush_cnt_o(b_fcnt), .stall_cnt_o(b_scnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Priority rules straight from the behaviour description.
    function automatic outs_t model_out(input int rem);
        outs_t o;
        logic  lu;
        o  = '0;
        lu = ex_load_i && ex_reg_wen_i && (ex_rd_addr_i != 5'd0) &&
             ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
              (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));
        if (rst !== 1'b1) return o;
        if (jump_en_i) begin
            o.jump_en = 1'b1;
            o.addr    = jump_addr_i;
            o.fif     = 1'b1;
            o.fidex   = 1'b1;
        end else if (rem > 0) begin
            o.fif   = 1'b1;
            o.fidex = 1'b1;
        end else if (ex_busy_i) begin
            o.hold  = 1'b1;
            o.stall = 1'b1;
        end else if (lu || ext_hold_i) begin
            o.hold  = 1'b1;
            o.stall = 1'b1;
            o.fidex = 1'b1;
        end
        return o;
    endfunction

    function automatic int next_rem(input int rem, input int jfc);
        if (jump_en_i) return jfc - 1;
        return (rem > 0) ? rem - 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_a <= 0; rem_b <= 0;
            fc_a  <= 0; sc_a  <= 0; fc_b <= 0; sc_b <= 0;
        end else begin
            fc_a  <= fc_a + int'(jump_en_i || rem_a > 0);
            fc_b  <= fc_b + int'(jump_en_i || rem_b > 0);
            sc_a  <= sc_a + int'(model_out(rem_a).hold);
            sc_b  <= sc_b + int'(model_out(rem_b).hold);
            rem_a <= next_rem(rem_a, JFC_A);
            rem_b <= next_rem(rem_b, JFC_B);
        end
    end

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(c % (1 << CW));
`else
        return (c < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        outs_t ea, eb;
        ea = model_out(rem_a);
        eb = model_out(rem_b);
        check("a_jump_en", a_jump_en, ea.jump_en);
        check("a_addr",    a_addr,    ea.addr);
        check("a_hold",    a_hold,    ea.hold);
        check("a_stall",   a_stall,   ea.stall);
        check("a_fif",     a_fif,     ea.fif);
        check("a_fidex",   a_fidex,   ea.fidex);
        check("a_fcnt",    a_fcnt,    exp_cnt(fc_a));
        check("a_scnt",    a_scnt,    exp_cnt(sc_a));
        check("b_jump_en", b_jump_en, eb.jump_en);
        check("b_addr",    b_addr,    eb.addr);
        check("b_hold",    b_hold,    eb.hold);
        check("b_stall",   b_stall,   eb.stall);
        check("b_fif",     b_fif,     eb.fif);
        check("b_fidex",   b_fidex,   eb.fidex);
        check("b_fcnt",    b_fcnt,    exp_cnt(fc_b));
        check("b_scnt",    b_scnt,    exp_cnt(sc_b));
        check("a_fif_stall_excl", 32'(a_fif && a_stall), 32'd0);
        check("b_fif_stall_excl", 32'(b_fif && b_stall), 32'd0);
    end

    task automatic clear_inputs();
        jump_en_i = 1'b0; jump_addr_i = '0; ex_busy_i = 1'b0; ex_load_i = 1'b0;
        ex_rd_addr_i = '0; ex_reg_wen_i = 1'b0; id_rs1_addr_i = '0; id_rs1_ren_i = 1'b0;
        id_rs2_addr_i = '0; id_rs2_ren_i = 1'b0; ext_hold_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #2;
        check("rst_jump_en", a_jump_en, 0);
        check("rst_hold",    b_hold,    0);
        check("rst_fcnt",    a_fcnt,    0);
        check("rst_scnt",    b_scnt,    0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Jump: immediate redirect; the 1-cycle instance is clean next cycle, the 3-cycle one drains.
        jump_en_i = 1'b1; jump_addr_i = 32'h100;
        @(negedge clk);
        check("t1_jump_en", a_jump_en, 1);
        check("t1_addr",    a_addr,    32'h100);
        check("t1_fif",     a_fif,     1);
        check("t1_fidex",   a_fidex,   1);
        check("t1_hold",    a_hold,    0);
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("t1_next_fif",   a_fif,     0);
        check("t1_next_fidex", a_fidex,   0);
        check("t1_next_jump",  a_jump_en, 0);
        check("t1_next_addr",  a_addr,    0);
        check("t2_b_c1",       b_fif,     1);
        next_cycle(); @(negedge clk);
        check("t2_b_c2", b_fidex, 1);
        next_cycle(); @(negedge clk);
        check("t2_b_c3", b_fif, 0);

        // Back-to-back jumps restart the flush window.
        next_cycle(); jump_en_i = 1'b1; jump_addr_i = 32'h200;
        next_cycle();
        next_cycle(); clear_inputs();
        @(negedge clk);
        check("t2r_c2_fif",  b_fif,     1);
        check("t2r_c2_jump", b_jump_en, 0);
        next_cycle(); @(negedge clk);
        check("t2r_c3_fif", b_fif, 1);
        next_cycle(); @(negedge clk);
        check("t2r_c4_fif", b_fif, 0);

        // Load-use bubble and its two non-hazard variants.
        next_cycle();
        ex_load_i = 1'b1; ex_reg_wen_i = 1'b1; ex_rd_addr_i = 5'd5;
        id_rs2_addr_i = 5'd5; id_rs2_ren_i = 1'b1;
        @(negedge clk);
        check("t3_hold",  a_hold,  1);
        check("t3_stall", a_stall, 1);
        check("t3_fidex", a_fidex, 1);
        check("t3_fif",   a_fif,   0);
        next_cycle(); ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        @(negedge clk);
        check("t3_x0_hold", a_hold, 0);
        next_cycle(); ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_ren_i = 1'b0;
        @(negedge clk);
        check("t3_noren_hold", a_hold, 0);

        // Busy dominates load-use and external hold; the bubble follows once busy drops.
        next_cycle(); id_rs2_ren_i = 1'b1; ext_hold_i = 1'b1; ex_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_busy_hold",  a_hold,  1);
            check("t4_busy_fidex", a_fidex, 0);
            next_cycle();
        end
        ex_busy_i = 1'b0;
        @(negedge clk);
        check("t4_after_hold",  a_hold,  1);
        check("t4_after_fidex", a_fidex, 1);

        // Jump beats busy and load-use in the same cycle.
        next_cycle(); ex_busy_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h300;
        @(negedge clk);
        check("t5_fif",   a_fif,   1);
        check("t5_fidex", a_fidex, 1);
        check("t5_hold",  a_hold,  0);
        check("t5_stall", a_stall, 0);

        // Asynchronous reset in the middle of a flush window, then three counted stalls.
        next_cycle(); clear_inputs(); jump_en_i = 1'b1;
        next_cycle(); jump_en_i = 1'b0;
        #1 check("t6_pre_fif", b_fif, 1);
        #1 rst = 1'b0;
        #1;
        check("t6_rst_fif",   b_fif,   0);
        check("t6_rst_fidex", b_fidex, 0);
        check("t6_rst_fcnt",  b_fcnt,  0);
        check("t6_rst_scnt",  a_scnt,  0);
        next_cycle(); rst = 1'b1; ext_hold_i = 1'b1;
        next_cycle(); next_cycle(); next_cycle(); clear_inputs();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("t6_scnt3", a_scnt, 3);
`else
        check("t6_scnt3", a_scnt, 0);
`endif
        check("t6_fcnt0", a_fcnt, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            jump_en_i     = ($urandom_range(0, 9) == 0);
            jump_addr_i   = $urandom;
            ex_busy_i     = ($urandom_range(0, 5) == 0);
            ext_hold_i    = ($urandom_range(0, 5) == 0);
            ex_load_i     = ($urandom_range(0, 1) == 0);
            ex_reg_wen_i  = ($urandom_range(0, 3) != 0);
            ex_rd_addr_i  = 5'($urandom_range(0, 3));
            id_rs1_addr_i = 5'($urandom_range(0, 3));
            id_rs2_addr_i = 5'($urandom_range(0, 3));
            id_rs1_ren_i  = ($urandom_range(0, 3) != 0);
            id_rs2_ren_i  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b0;
                next_cycle();
                rst = 1'b1;
            end
        end
        next_cycle(); clear_inputs();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
